// File: rtl/pulse_sched.sv
// Round-robin scheduler sharing one pulse generator among N_REQ requesters:
// grant, launch, wait for done (or time out), then hold off for GAP cycles.
module pulse_sched #(
    parameter int N_REQ   = 4,
    parameter int LEN_W   = 5,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*LEN_W-1:0]   req_len,
    output logic [N_REQ-1:0]         ack,
    output logic                     err,
    output logic [$clog2(N_REQ)-1:0] cur_id,
    output logic                     busy,
    output logic                     gen_start,
    output logic [LEN_W-1:0]         gen_len,
    input  logic                     gen_done
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + GAP + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [ID_W-1:0]    ptr_r, ptr_s;
    logic [ID_W-1:0]    cur_id_r, cur_id_s;
    logic [LEN_W-1:0]   gen_len_r, gen_len_s;
    logic [N_REQ-1:0]   ack_r, ack_s;
    logic               err_r, err_s;
    logic               gen_start_r, gen_start_s;
    logic               busy_r, busy_s;
    logic [ID_W:0]      pick_s;
    logic [ID_W-1:0]    pick_id_s;
    logic [LEN_W-1:0]   pick_len_s;

    // Returns {valid, id} of the first asserted request searching from p upward, wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r, input logic [ID_W-1:0] p);
        logic [ID_W:0] res;
        int unsigned   idx;
        res = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = 32'(p) + i;
            if (idx >= 32'(N_REQ)) idx = idx - 32'(N_REQ);
            if (!res[ID_W] && r[idx[ID_W-1:0]]) res = {1'b1, idx[ID_W-1:0]};
        end
        return res;
    endfunction

    function automatic logic [LEN_W-1:0] len_of(input logic [N_REQ*LEN_W-1:0] l, input logic [ID_W-1:0] id);
        logic [LEN_W-1:0] res;
        res = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == id) res = l[i*LEN_W +: LEN_W];
        end
        return res;
    endfunction

    // With no gap configured, service exits straight back to arbitration.
    function automatic state_t exit_state();
        if (GAP == 0) return S_IDLE;
        else return S_GAP;
    endfunction

    assign pick_s     = rr_pick(req, ptr_r);
    assign pick_id_s  = pick_s[ID_W-1:0];
    assign pick_len_s = len_of(req_len, pick_id_s);

    // Next-state and next-output computation.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        ptr_s       = ptr_r;
        cur_id_s    = cur_id_r;
        gen_len_s   = gen_len_r;
        ack_s       = '0;
        err_s       = 1'b0;
        gen_start_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (pick_s[ID_W]) begin
                    cur_id_s  = pick_id_s;
                    gen_len_s = pick_len_s;
                    ptr_s     = (pick_id_s == ID_LAST) ? '0 : pick_id_s + ID_W'(1);
                    cnt_s     = '0;
                    if (pick_len_s != '0) begin
                        state_s = S_START;
                    end else begin
                        ack_s[pick_id_s] = 1'b1;
                        state_s          = exit_state();
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                gen_start_s = 1'b1;
                cnt_s       = '0;
                state_s     = S_WAIT;
            end
            S_WAIT: begin
                if (gen_done) begin
                    ack_s[cur_id_r] = 1'b1;
                    cnt_s           = '0;
                    state_s         = exit_state();
                end else if (cnt_r == TO_LAST) begin
                    err_s   = 1'b1;
                    cnt_s   = '0;
                    state_s = exit_state();
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_s   = '0;
                    state_s = S_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                cnt_s   = '0;
                state_s = S_IDLE;
            end
        endcase
        busy_s = (state_s != S_IDLE);
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            cnt_r       <= '0;
            ptr_r       <= '0;
            cur_id_r    <= '0;
            gen_len_r   <= '0;
            ack_r       <= '0;
            err_r       <= 1'b0;
            gen_start_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            ptr_r       <= ptr_s;
            cur_id_r    <= cur_id_s;
            gen_len_r   <= gen_len_s;
            ack_r       <= ack_s;
            err_r       <= err_s;
            gen_start_r <= gen_start_s;
            busy_r      <= busy_s;
        end
    end

    assign ack       = ack_r;
    assign err       = err_r;
    assign cur_id    = cur_id_r;
    assign busy      = busy_r;
    assign gen_start = gen_start_r;
    assign gen_len   = gen_len_r;

endmodule

// File: tb/tb_pulse_sched.sv
// Directed bench for pulse_sched: per-cycle vector table plus hand-written
// timeout, single-service and round-robin fairness sequences.
module tb_pulse_sched;
    localparam int N_REQ   = 4;
    localparam int LEN_W   = 5;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 64;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [19:0] req_len;
    logic [3:0]  ack;
    logic        err;
    logic [1:0]  cur_id;
    logic        busy;
    logic        gen_start;
    logic [4:0]  gen_len;
    logic        gen_done;

    int checks = 0;
    int errors = 0;

    pulse_sched #(.N_REQ(N_REQ), .LEN_W(LEN_W), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .ack(ack), .err(err),
        .cur_id(cur_id), .busy(busy), .gen_start(gen_start), .gen_len(gen_len),
        .gen_done(gen_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [19:0] lens;
        logic        done;
        logic [3:0]  ack;
        logic        err;
        logic        busy;
        logic        gs;
        logic [1:0]  id;
        logic [4:0]  glen;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [19:0] pk(input logic [4:0] l3, input logic [4:0] l2,
                                       input logic [4:0] l1, input logic [4:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic add(input logic r, input logic [3:0] q, input logic [19:0] l, input logic d,
                       input logic [3:0] a, input logic e, input logic b, input logic g,
                       input logic [1:0] i, input logic [4:0] gl);
        vec_t v;
        v.rst = r; v.req = q; v.lens = l; v.done = d;
        v.ack = a; v.err = e; v.busy = b; v.gs = g; v.id = i; v.glen = gl;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [19:0] la, lz, lb;
        int n, gs_cnt, stray, cd, exp_idx, ack_t;
        logic saw_ack, prev_busy;

        rst = 1'b1; req = 4'b0000; req_len = '0; gen_done = 1'b0;
        la = pk(5'd0, 5'd0, 5'd0, 5'd3);
        lz = pk(5'd0, 5'd0, 5'd0, 5'd0);
        lb = pk(5'd7, 5'd0, 5'd0, 5'd5);

        //   rst  req      lens done | ack      err   busy  gs    id     glen
        add(1'b1, 4'b0000, la, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0);
        add(1'b1, 4'b1111, la, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0);
        add(1'b0, 4'b0000, la, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0);
        add(1'b0, 4'b0001, la, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 5'd3);
        add(1'b0, 4'b0001, la, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 5'd3);
        add(1'b0, 4'b0001, la, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 5'd3);
        add(1'b0, 4'b0001, la, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd0, 5'd3);
        add(1'b0, 4'b0000, la, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 5'd3);
        add(1'b0, 4'b0000, la, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 5'd3);
        add(1'b0, 4'b0100, lz, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 2'd2, 5'd0);
        add(1'b0, 4'b0000, lz, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 5'd0);
        add(1'b0, 4'b0000, lz, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 5'd0);
        add(1'b0, 4'b1001, lb, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd3, 5'd7);
        add(1'b0, 4'b1001, lb, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd3, 5'd7);
        add(1'b0, 4'b0001, lb, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd3, 5'd7);
        add(1'b0, 4'b0001, lb, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 2'd3, 5'd7);
        add(1'b0, 4'b0001, lb, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd3, 5'd7);
        add(1'b0, 4'b0001, lb, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 5'd7);
        add(1'b0, 4'b0001, lb, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 5'd5);
        add(1'b0, 4'b0001, lb, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 5'd5);
        add(1'b1, 4'b0001, lb, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0);
        add(1'b0, 4'b0000, lb, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0);
        add(1'b0, 4'b1001, lb, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 5'd5);
        add(1'b0, 4'b1001, lb, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 5'd5);
        add(1'b0, 4'b1001, lb, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd0, 5'd5);
        add(1'b0, 4'b0000, lb, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 5'd5);
        add(1'b0, 4'b0000, lb, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 5'd5);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; req = vecs[i].req; req_len = vecs[i].lens; gen_done = vecs[i].done;
            tick();
            chk($sformatf("vec%0d{ack,err,busy,gs,id,len}", i),
                32'({ack, err, busy, gen_start, cur_id, gen_len}),
                32'({vecs[i].ack, vecs[i].err, vecs[i].busy, vecs[i].gs, vecs[i].id, vecs[i].glen}));
        end
        rst = 1'b0; gen_done = 1'b0; req = 4'b0000;

        // Timeout: requester 1, generator never answers.
        req = 4'b0010; req_len = pk(5'd0, 5'd0, 5'd4, 5'd0);
        tick();
        chk("to_grant", 32'({busy, cur_id, gen_len}), 32'({1'b1, 2'd1, 5'd4}));
        tick();
        chk("to_start", 32'(gen_start), 32'd1);
        n = 0; saw_ack = 1'b0;
        while (n < 100 && !err) begin
            tick();
            n++;
            if (ack != 4'b0000) saw_ack = 1'b1;
        end
        chk("to_err_delay", 32'(n), 32'(TIMEOUT));
        chk("to_err_id", 32'(cur_id), 32'd1);
        chk("to_no_ack", 32'(saw_ack), 32'd0);
        req = 4'b0000;
        tick();
        chk("to_err_pulse", 32'({err, busy}), 32'({1'b0, 1'b1}));
        tick();
        chk("to_idle", 32'(busy), 32'd0);

        // Single service after the timeout: requester 3, length 9, done 10 cycles after start.
        req = 4'b1000; req_len = pk(5'd9, 5'd0, 5'd0, 5'd0);
        tick();
        chk("one_grant", 32'({busy, cur_id, gen_len}), 32'({1'b1, 2'd3, 5'd9}));
        tick();
        chk("one_start", 32'(gen_start), 32'd1);
        gs_cnt = 1; stray = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (gen_start) gs_cnt++;
            if (ack != 4'b0000 || !busy || gen_len != 5'd9) stray++;
        end
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        chk("one_ack", 32'({ack, err}), 32'({4'b1000, 1'b0}));
        chk("one_gs_count", 32'(gs_cnt), 32'd1);
        chk("one_stray", 32'(stray), 32'd0);
        req = 4'b0000;
        tick();
        chk("one_gap", 32'({ack, busy}), 32'({4'b0000, 1'b1}));
        tick();
        chk("one_idle", 32'(busy), 32'd0);

        // Fairness: all four request, each drops after its ack; then all re-raise.
        req = 4'b1111; req_len = pk(5'd5, 5'd4, 5'd3, 5'd2);
        exp_idx = 0; ack_t = -1; cd = 0; prev_busy = busy;
        for (int c = 0; c < 400 && exp_idx < 8; c++) begin
            tick();
            if (gen_done) gen_done = 1'b0;
            if (busy && !prev_busy) begin
                chk("rr_grant_id", 32'(cur_id), 32'(exp_idx % 4));
                chk("rr_grant_len", 32'(gen_len), 32'((exp_idx % 4) + 2));
                if (ack_t >= 0) chk("rr_ack_to_grant", 32'(c - ack_t), 32'(GAP + 1));
            end
            if (gen_start) begin
                cd = 3;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) gen_done = 1'b1;
            end
            if (ack != 4'b0000) begin
                chk("rr_ack", 32'(ack), 32'd1 << (exp_idx % 4));
                req = req & ~ack;
                ack_t = c;
                exp_idx++;
                if (req == 4'b0000 && exp_idx == 4) req = 4'b1111;
            end
            prev_busy = busy;
        end
        chk("rr_service_count", 32'(exp_idx), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
